// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - resolved-branch FIFO feeding the BTB update port, with registered redirect
// Head entry drives result_* combinationally; mispredict/redirect_PC are registered from the enqueue cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SD
`define SD
`endif

module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [`XLEN-1:0]   ex_PC,
  input  logic               ex_taken,
  input  logic [`XLEN-1:0]   ex_target_PC,
  input  logic               ex_pred_taken,
  input  logic [`XLEN-1:0]   ex_pred_target_PC,
  input  logic               result_ready,
  output logic               result_branch,
  output logic               result_taken,
  output logic [`XLEN-1:0]   result_PC,
  output logic [`XLEN-1:0]   result_target_PC,
  output logic               mispredict,
  output logic [`XLEN-1:0]   redirect_PC,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [`XLEN-1:0] r_pc_mem    [DEPTH];
  logic [`XLEN-1:0] r_tgt_mem   [DEPTH];
  logic             r_taken_mem [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_mispredict;
  logic [`XLEN-1:0] r_redirect_PC;

  logic             w_enq;
  logic             w_deq;
  logic             w_empty;
  logic             w_mispred;
  logic [`XLEN-1:0] w_next_pc;

  // ex_ready looks only at occupancy, so a full queue never accepts even while draining.
  assign ex_ready  = (r_count < CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_enq     = ex_valid && ex_ready;
  assign w_deq     = !w_empty && result_ready;

  assign w_mispred = (ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target_PC != ex_pred_target_PC));
  assign w_next_pc = ex_taken ? ex_target_PC : (ex_PC + `XLEN'(4));

  assign result_branch    = !w_empty;
  assign result_taken     = w_empty ? 1'b0 : r_taken_mem[r_head];
  assign result_PC        = w_empty ? '0   : r_pc_mem[r_head];
  assign result_target_PC = w_empty ? '0   : r_tgt_mem[r_head];

  assign mispredict  = r_mispredict;
  assign redirect_PC = r_redirect_PC;
  assign count       = r_count;

  // Entry storage is deliberately left out of reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (!reset && w_enq) begin
      r_pc_mem[r_tail]    <= `SD ex_PC;
      r_tgt_mem[r_tail]   <= `SD ex_target_PC;
      r_taken_mem[r_tail] <= `SD ex_taken;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head        <= `SD '0;
      r_tail        <= `SD '0;
      r_count       <= `SD '0;
      r_mispredict  <= `SD 1'b0;
      r_redirect_PC <= `SD '0;
    end else begin
      if (w_enq) begin
        r_tail <= `SD r_tail + 1'b1;
      end
      if (w_deq) begin
        r_head <= `SD r_head + 1'b1;
      end
      if (w_enq && !w_deq) begin
        r_count <= `SD r_count + 1'b1;
      end else if (!w_enq && w_deq) begin
        r_count <= `SD r_count - 1'b1;
      end
      r_mispredict <= `SD w_enq && w_mispred;
      if (w_enq && w_mispred) begin
        r_redirect_PC <= `SD w_next_pc;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed self-checking bench for branch_resolve_queue
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_branch_resolve_queue;

  logic        clock;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_PC;
  logic        ex_taken;
  logic [31:0] ex_target_PC;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target_PC;
  logic        result_ready;
  logic        result_branch;
  logic        result_taken;
  logic [31:0] result_PC;
  logic [31:0] result_target_PC;
  logic        mispredict;
  logic [31:0] redirect_PC;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  branch_resolve_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clock             (clock),
    .reset             (reset),
    .ex_valid          (ex_valid),
    .ex_ready          (ex_ready),
    .ex_PC             (ex_PC),
    .ex_taken          (ex_taken),
    .ex_target_PC      (ex_target_PC),
    .ex_pred_taken     (ex_pred_taken),
    .ex_pred_target_PC (ex_pred_target_PC),
    .result_ready      (result_ready),
    .result_branch     (result_branch),
    .result_taken      (result_taken),
    .result_PC         (result_PC),
    .result_target_PC  (result_target_PC),
    .mispredict        (mispredict),
    .redirect_PC       (redirect_PC),
    .count             (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid          = v;
    ex_PC             = pc;
    ex_taken          = tk;
    ex_target_PC      = tgt;
    ex_pred_taken     = ptk;
    ex_pred_target_PC = ptgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    result_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_count",    32'(count),         32'd0);
    chk("rst_ex_ready", 32'(ex_ready),      32'd1);
    chk("rst_branch",   32'(result_branch), 32'd0);
    chk("rst_mispred",  32'(mispredict),    32'd0);
    chk("rst_redirect", redirect_PC,        32'h0);
    chk("rst_res_pc",   result_PC,          32'h0);

    // correctly predicted taken branch, drained immediately
    result_ready = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hit_branch",  32'(result_branch), 32'd1);
    chk("hit_pc",      result_PC,          32'h100);
    chk("hit_tgt",     result_target_PC,   32'h200);
    chk("hit_taken",   32'(result_taken),  32'd1);
    chk("hit_mispred", 32'(mispredict),    32'd0);
    chk("hit_count",   32'(count),         32'd1);
    tick();
    chk("hit_drained", 32'(count),         32'd0);
    chk("hit_empty_pc", result_PC,         32'h0);

    // direction mispredict: not taken but predicted taken
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("dir_mispred",  32'(mispredict),   32'd1);
    chk("dir_redirect", redirect_PC,       32'h44);
    chk("dir_nt_taken", 32'(result_taken), 32'd0);
    tick();
    chk("dir_pulse_end", 32'(mispredict),  32'd0);
    chk("dir_hold",      redirect_PC,      32'h44);
    chk("dir_count",     32'(count),       32'd0);

    // target mispredict followed back-to-back by a direction mispredict at the top of memory
    drive(1'b1, 32'h60, 1'b1, 32'h80, 1'b1, 32'h90);
    tick();
    chk("tgt_mispred",  32'(mispredict), 32'd1);
    chk("tgt_redirect", redirect_PC,     32'h80);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("b2b_mispred",  32'(mispredict), 32'd1);
    chk("b2b_redirect", redirect_PC,     32'h0);
    tick();
    chk("b2b_end",   32'(mispredict), 32'd0);
    chk("b2b_count", 32'(count),      32'd0);

    // fill to DEPTH with result_ready low; the 5th branch is a would-be mispredict
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(i) * 32'h10, 1'b1, 32'h1100 + 32'(i) * 32'h10,
            1'b1, 32'h1100 + 32'(i) * 32'h10);
      tick();
      chk($sformatf("fill_count_%0d", i), 32'(count), 32'(i + 1));
    end
    chk("full_ex_ready", 32'(ex_ready), 32'd0);
    drive(1'b1, 32'h1040, 1'b1, 32'h5000, 1'b0, 32'h0);
    tick();
    chk("full_ignored_mispred", 32'(mispredict), 32'd0);
    chk("full_ignored_count",   32'(count),      32'd4);
    chk("full_head_pc",         result_PC,       32'h1000);

    // full while draining: still no enqueue
    result_ready = 1'b1;
    drive(1'b1, 32'h9990, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("full_deq_count",   32'(count),      32'd3);
    chk("full_deq_mispred", 32'(mispredict), 32'd0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain_pc_%0d", i),  result_PC,        32'h1000 + 32'(i) * 32'h10);
      chk($sformatf("drain_tgt_%0d", i), result_target_PC, 32'h1100 + 32'(i) * 32'h10);
      tick();
    end
    chk("drain_empty",  32'(result_branch), 32'd0);
    chk("drain_count",  32'(count),         32'd0);

    // steady state at count 2 with simultaneous enqueue/dequeue across pointer wrap
    result_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h2000 + 32'(i) * 32'h10, 1'b1, 32'h2100 + 32'(i) * 32'h10,
            1'b1, 32'h2100 + 32'(i) * 32'h10);
      tick();
    end
    chk("ss_pre_count", 32'(count), 32'd2);
    result_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h2020 + 32'(i) * 32'h10, 1'b1, 32'h2120 + 32'(i) * 32'h10,
            1'b1, 32'h2120 + 32'(i) * 32'h10);
      chk($sformatf("ss_head_%0d", i), result_PC, 32'h2000 + 32'(i) * 32'h10);
      tick();
      chk($sformatf("ss_count_%0d", i), 32'(count), 32'd2);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("ss_tail0", result_PC, 32'h2080);
    tick();
    chk("ss_tail1", result_PC, 32'h2090);
    tick();
    chk("ss_done", 32'(count), 32'd0);

    // reset with count 3 and a mispredict pulse outstanding, plus a same-cycle enqueue
    result_ready = 1'b0;
    drive(1'b1, 32'h3000, 1'b1, 32'h3100, 1'b1, 32'h3100);
    tick();
    drive(1'b1, 32'h3010, 1'b1, 32'h3110, 1'b1, 32'h3110);
    tick();
    drive(1'b1, 32'h3020, 1'b0, 32'h0, 1'b1, 32'h3120);
    tick();
    chk("pre_rst_count",   32'(count),      32'd3);
    chk("pre_rst_mispred", 32'(mispredict), 32'd1);
    reset        = 1'b1;
    result_ready = 1'b1;
    drive(1'b1, 32'h3030, 1'b0, 32'h0, 1'b1, 32'h3130);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst2_count",    32'(count),         32'd0);
    chk("rst2_branch",   32'(result_branch), 32'd0);
    chk("rst2_mispred",  32'(mispredict),    32'd0);
    chk("rst2_redirect", redirect_PC,        32'h0);
    chk("rst2_ex_ready", 32'(ex_ready),      32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
